rand_num_gen_63: RTL and testbench



---
 rtl/rand_num_gen_63.sv | 102 ++++++++++
 tb/tb_rand_num_gen_63.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/rand_num_gen_63.sv
// rand_num_gen_63: free-running 6-bit maximal-length LFSR (x^6+x^5+1),
// period 63, never zero. Gameplay instantiates one per axis with distinct seeds.
//
// Optional feature macro: RNG_FIT_EN
//   defined     -> rnd_fit = 1 + (rnd mod FIT_RANGE), combinational from rnd
//   not defined -> rnd_fit tied to zero, no modulo logic
//
// Parameters:
//   FIT_RANGE  modulus for rnd_fit, legal 1..63 (default 60)
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous active-high reset, loads fixed-up seed
//   en       in   advance enable
//   load     in   synchronous reseed strobe (same effect as reset)
//   seed     in   6-bit seed, zero is replaced by 6'b000001
//   rnd      out  current LFSR state (registered)
//   rnd_fit  out  range-reduced value (combinational from rnd)
//   wrap     out  one-cycle pulse when the sequence returns to its start value
module rand_num_gen_63 #(
   parameter int unsigned FIT_RANGE = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       load,
   input  logic [5:0] seed,
   output logic [5:0] rnd,
   output logic [5:0] rnd_fit,
   output logic       wrap
);

   localparam int unsigned W         = 6;
   localparam logic [W-1:0] LAST_STEP = W'(62);

   // Elaboration-time guard on the modulus
   if (FIT_RANGE < 1 || FIT_RANGE > 63) begin : g_bad_fit_range
      $error("rand_num_gen_63: FIT_RANGE=%0d outside 1..63", FIT_RANGE);
   end

   logic [W-1:0] s_q, s_d;
   logic [W-1:0] start_q, start_d;
   logic [W-1:0] cnt_q, cnt_d;
   logic         wrap_q, wrap_d;
   logic [W-1:0] seed_fix;
   logic [W-1:0] s_adv;

   // All-zero is the LFSR lock-up state, so a zero seed becomes 1
   assign seed_fix = (seed == '0) ? W'(1) : seed;

   // Fibonacci shift-left step
   assign s_adv = {s_q[W-2:0], s_q[W-1] ^ s_q[W-2]};

   // Next-state: load beats advance, advance beats hold
   always_comb begin
      s_d     = s_q;
      start_d = start_q;
      cnt_d   = cnt_q;
      wrap_d  = 1'b0;
      if (load) begin
         s_d     = seed_fix;
         start_d = seed_fix;
         cnt_d   = '0;
      end else if (en) begin
         s_d = s_adv;
         if (cnt_q == LAST_STEP) begin
            cnt_d  = '0;
            // For a maximal-length LFSR the 63rd advance always lands on start
            wrap_d = (s_adv == start_q);
         end else begin
            cnt_d = cnt_q + W'(1);
         end
      end
   end

   // State register with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         s_q     <= seed_fix;
         start_q <= seed_fix;
         cnt_q   <= '0;
         wrap_q  <= 1'b0;
      end else begin
         s_q     <= s_d;
         start_q <= start_d;
         cnt_q   <= cnt_d;
         wrap_q  <= wrap_d;
      end
   end

   assign rnd  = s_q;
   assign wrap = wrap_q;

`ifdef RNG_FIT_EN
   // Range reduction to 1..FIT_RANGE, valid in the same cycle as rnd
   always_comb begin
      rnd_fit = (s_q % W'(FIT_RANGE)) + W'(1);
   end
`else
   assign rnd_fit = '0;
`endif

endmodule

// File: tb/tb_rand_num_gen_63.sv
// Directed self-checking bench for rand_num_gen_63.
module tb_rand_num_gen_63;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic       load;
   logic [5:0] seed;
   logic [5:0] rnd;
   logic [5:0] rnd_fit;
   logic       wrap;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   rand_num_gen_63 #(.FIT_RANGE(60)) dut (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .load    (load),
      .seed    (seed),
      .rnd     (rnd),
      .rnd_fit (rnd_fit),
      .wrap    (wrap)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one edge, then sample away from it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [5:0] s);
      seed  = s;
      reset = 1'b1;
      en    = 1'b0;
      load  = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   function automatic logic [5:0] lfsr(input logic [5:0] s);
      return {s[4:0], s[5] ^ s[4]};
   endfunction

   function automatic logic [5:0] fit_exp(input logic [5:0] r);
`ifdef RNG_FIT_EN
      return 6'((r % 6'd60) + 6'd1);
`else
      return 6'd0;
`endif
   endfunction

   logic [5:0]  seq1 [3]  = '{6'b001101, 6'b011010, 6'b110101};
   logic [5:0]  seq0 [5]  = '{6'b000010, 6'b000100, 6'b001000, 6'b010000, 6'b100001};
   logic [63:0] seen;
   logic [5:0]  exp_s;
   logic [5:0]  fexp;

   initial begin
      reset = 1'b0; en = 1'b0; load = 1'b0; seed = '0;

      // Seed sequence
      do_reset(6'b100110);
      chk("reset_rnd", 64'(rnd), 64'(6'b100110));
      chk("reset_wrap", 64'(wrap), 64'd0);
      chk("reset_fit", 64'(rnd_fit), 64'(fit_exp(6'b100110)));
      en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("seq1_%0d", i), 64'(rnd), 64'(seq1[i]));
      end

      // Zero seed fix-up and never-zero
      do_reset(6'b000000);
      chk("zero_seed_rnd", 64'(rnd), 64'(6'b000001));
      en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("seq0_%0d", i), 64'(rnd), 64'(seq0[i]));
      end
      for (int i = 0; i < 200; i++) begin
         tick();
         total++;
         assert (rnd !== 6'd0) else begin
            bad++;
            $error("FAIL nonzero_%0d observed=%0h expected=nonzero", i, rnd);
         end
      end

      // Period, uniqueness and wrap timing
      do_reset(6'b100110);
      en   = 1'b1;
      seen = '0;
      for (int k = 1; k <= 130; k++) begin
         tick();
         chk($sformatf("period_wrap_%0d", k), 64'(wrap), 64'((k == 63 || k == 126) ? 1 : 0));
         chk($sformatf("period_fit_%0d", k), 64'(rnd_fit), 64'(fit_exp(rnd)));
         total++;
         assert (!seen[rnd]) else begin
            bad++;
            $error("FAIL dup_%0d observed=%0h expected=unseen", k, rnd);
         end
         seen[rnd] = 1'b1;
         if (k == 63 || k == 126) begin
            chk($sformatf("period_start_%0d", k), 64'(rnd), 64'(6'b100110));
            chk($sformatf("period_all_%0d", k), seen, 64'hFFFF_FFFF_FFFF_FFFE);
            seen = '0;
         end
      end

      // Pause holds value and wrap timing
      do_reset(6'b011011);
      exp_s = 6'b011011;
      en    = 1'b1;
      for (int i = 0; i < 60; i++) begin
         tick();
         exp_s = lfsr(exp_s);
      end
      chk("pause_pre", 64'(rnd), 64'(exp_s));
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("pause_rnd_%0d", i), 64'(rnd), 64'(exp_s));
         chk($sformatf("pause_wrap_%0d", i), 64'(wrap), 64'd0);
      end
      en = 1'b1;
      tick();
      chk("resume_61_wrap", 64'(wrap), 64'd0);
      tick();
      chk("resume_62_wrap", 64'(wrap), 64'd0);
      tick();
      chk("resume_63_wrap", 64'(wrap), 64'd1);
      chk("resume_63_rnd", 64'(rnd), 64'(6'b011011));
      en = 1'b0;
      tick();
      chk("pause_after_wrap", 64'(wrap), 64'd0);
      chk("pause_after_rnd", 64'(rnd), 64'(6'b011011));

      // Load mid-sequence with en high: load wins, count restarts
      en = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      seed = 6'b101001;
      load = 1'b1;
      tick();
      load = 1'b0;
      chk("load_rnd", 64'(rnd), 64'(6'b101001));
      chk("load_wrap", 64'(wrap), 64'd0);
      for (int i = 1; i <= 62; i++) begin
         tick();
         chk($sformatf("load_nowrap_%0d", i), 64'(wrap), 64'd0);
      end
      tick();
      chk("load_wrap_63", 64'(wrap), 64'd1);
      chk("load_start_63", 64'(rnd), 64'(6'b101001));
      seed = 6'b000000;
      load = 1'b1;
      tick();
      load = 1'b0;
      chk("load_zero_rnd", 64'(rnd), 64'(6'b000001));
      en = 1'b0;

      // Fit output corner values
`ifdef RNG_FIT_EN
      fexp = 6'd4;
`else
      fexp = 6'd0;
`endif
      do_reset(6'b111111);
      chk("fit_63", 64'(rnd_fit), 64'(fexp));
`ifdef RNG_FIT_EN
      fexp = 6'd1;
`else
      fexp = 6'd0;
`endif
      do_reset(6'b111100);
      chk("fit_60", 64'(rnd_fit), 64'(fexp));
`ifdef RNG_FIT_EN
      fexp = 6'd39;
`else
      fexp = 6'd0;
`endif
      do_reset(6'b100110);
      chk("fit_38", 64'(rnd_fit), 64'(fexp));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
